inv_sub_byte: RTL and testbench

- Decryption-side counterpart of sub_byte. Applies the AES inverse S-box to a 16-byte state.
- Owns a 256x8 inverse S-box RAM, loaded serially through a write port before use.
- Looks up LANES bytes per cycle and signals completion with a one-cycle done pulse.
- Sits in the decryption round datapath, between InvShiftRows and AddRoundKey.

---
 rtl/inv_sub_byte_if.sv | 22 ++
 rtl/inv_sub_byte.sv | 98 +++++++++
 tb/tb_inv_sub_byte.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_sub_byte_if.sv
// rtl/inv_sub_byte_if.sv - table-load and lookup handshake bundle for inv_sub_byte
interface inv_sub_byte_if;
   logic         wr_en;
   logic [7:0]   wr_addr;
   logic [7:0]   wr_data;
   logic         table_ready;
   logic         en;
   logic [127:0] state_in;
   logic         busy;
   logic [127:0] state_out;
   logic         done;

   modport master (
      output wr_en, wr_addr, wr_data, en, state_in,
      input  table_ready, busy, state_out, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, en, state_in,
      output table_ready, busy, state_out, done
   );
endinterface

// File: rtl/inv_sub_byte.sv
// rtl/inv_sub_byte.sv - AES inverse S-box over a 16-byte state from a loadable 256x8 RAM
module inv_sub_byte #(
   parameter int LANES = 4
) (
   input  logic           clk,
   input  logic           rst,
   inv_sub_byte_if.slave  bus
);
   localparam int GROUPS = 16 / LANES;
   localparam int GW     = $clog2(GROUPS);

   typedef enum logic [1:0] {IDLE, LOOKUP, DRAIN, DONE} state_t;

   state_t        state, state_nx;
   logic [7:0]    ram [256];
   logic [7:0]    rd_data [LANES];
   logic [127:0]  lat;
   logic [127:0]  result;
   logic [GW-1:0] grp;
   logic [GW-1:0] rd_grp;
   logic          rd_vld;
   logic [8:0]    wr_cnt;
   logic          start;
   logic          wr_ok;

   // DONE also accepts a new start so en held high chains operations back to back
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      wr_ok    = 1'b0;
      case (state)
         IDLE: begin
            wr_ok = bus.wr_en;
            if (bus.en && bus.table_ready) begin
               start    = 1'b1;
               state_nx = LOOKUP;
            end
         end
         LOOKUP: if (int'(grp) == GROUPS - 1) state_nx = DRAIN;
         DRAIN:  state_nx = DONE;
         DONE: begin
            if (bus.en && bus.table_ready) begin
               start    = 1'b1;
               state_nx = LOOKUP;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   assign bus.busy = (state != IDLE);

   // RAM contents deliberately survive reset; the table is reloaded by software
   always_ff @(posedge clk) begin
      if (wr_ok) ram[bus.wr_addr] <= bus.wr_data;
      for (int j = 0; j < LANES; j++)
         rd_data[j] <= ram[lat[127 - 8*(int'(grp)*LANES + j) -: 8]];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grp             <= '0;
         rd_grp          <= '0;
         rd_vld          <= 1'b0;
         lat             <= '0;
         result          <= '0;
         wr_cnt          <= '0;
         bus.table_ready <= 1'b0;
         bus.state_out   <= '0;
         bus.done        <= 1'b0;
      end else begin
         rd_vld   <= (state == LOOKUP);
         rd_grp   <= grp;
         bus.done <= (state == DONE);
         if (start) begin
            lat <= bus.state_in;
            grp <= '0;
         end else if (state == LOOKUP) begin
            grp <= grp + 1'b1;
         end
         // read data lags its address by one cycle, so it lands in the previous group's slot
         if (rd_vld) begin
            for (int j = 0; j < LANES; j++)
               result[127 - 8*(int'(rd_grp)*LANES + j) -: 8] <= rd_data[j];
         end
         if (state == DONE) bus.state_out <= result;
         if (wr_ok && wr_cnt != 9'd256) wr_cnt <= wr_cnt + 9'd1;
         bus.table_ready <= (wr_ok && wr_cnt == 9'd255) || (wr_cnt == 9'd256);
      end
   end
endmodule

// File: tb/tb_inv_sub_byte.sv
// tb/tb_inv_sub_byte.sv - randomized self-checking bench for inv_sub_byte at LANES 4, 2 and 1
module tb_inv_sub_byte;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inv_sub_byte_if b4 ();
   inv_sub_byte_if b2 ();
   inv_sub_byte_if b1 ();

   inv_sub_byte #(.LANES(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
   inv_sub_byte #(.LANES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
   inv_sub_byte #(.LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

   // narrower builds mirror every input of the LANES=4 instance
   assign b2.wr_en = b4.wr_en;  assign b2.wr_addr = b4.wr_addr;  assign b2.wr_data = b4.wr_data;
   assign b2.en    = b4.en;     assign b2.state_in = b4.state_in;
   assign b1.wr_en = b4.wr_en;  assign b1.wr_addr = b4.wr_addr;  assign b1.wr_data = b4.wr_data;
   assign b1.en    = b4.en;     assign b1.state_in = b4.state_in;

   int total = 0;
   int bad   = 0;
   logic [7:0]   inv_tab [256];
   int           lat_q [3];
   logic [127:0] res_q [3];
   int           pulses4;

   localparam logic [127:0] RT_IN  = 128'h637c777bf26b6fc53001ca82c97dfa59;
   localparam logic [127:0] RT_OUT = 128'h00010203040506070809101112131415;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [15:0] d = {v, v};
      logic [15:0] s = d << n;
      return s[15:8];
   endfunction

   // forward S-box from the GF(2^8) inverse plus affine map, then inverted
   task automatic build_model();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] v = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
         s = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
         inv_tab[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] st);
      logic [127:0] o = '0;
      for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = inv_tab[st[127 - 8*k -: 8]];
      return o;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_table();
      b4.wr_en = 1'b1;
      for (int a = 0; a < 256; a++) begin
         b4.wr_addr = 8'(a);
         b4.wr_data = inv_tab[a];
         step();
      end
      b4.wr_en = 1'b0;
   endtask

   task automatic run(input logic [127:0] st);
      b4.state_in = st;
      b4.en = 1'b1;
      step();
      b4.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lat_q[i] = -1;
         res_q[i] = '0;
      end
      pulses4 = 0;
      for (int n = 1; n <= 30; n++) begin
         step();
         if (b4.done) begin
            pulses4++;
            if (lat_q[2] < 0) begin lat_q[2] = n; res_q[2] = b4.state_out; end
         end
         if (b2.done && lat_q[1] < 0) begin lat_q[1] = n; res_q[1] = b2.state_out; end
         if (b1.done && lat_q[0] < 0) begin lat_q[0] = n; res_q[0] = b1.state_out; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      b4.wr_en = 1'b0; b4.wr_addr = '0; b4.wr_data = '0; b4.en = 1'b0; b4.state_in = '0;
      step();
      step();
      total++; if (b4.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", b4.busy); end
      total++; if (b4.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", b4.done); end
      total++; if (b4.table_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", b4.table_ready); end
      total++; if (b4.state_out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", b4.state_out); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_load();
      logic seen_busy = 1'b0;
      b4.wr_en = 1'b1;
      for (int a = 0; a < 255; a++) begin
         b4.wr_addr = 8'(a);
         b4.wr_data = inv_tab[a];
         step();
      end
      b4.wr_en = 1'b0;
      total++; if (b4.table_ready !== 1'b0) begin bad++; $display("FAIL ready_early got=%b exp=0", b4.table_ready); end
      b4.en = 1'b1;
      b4.state_in = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         step();
         if (b4.busy !== 1'b0) seen_busy = 1'b1;
      end
      b4.en = 1'b0;
      total++; if (seen_busy !== 1'b0) begin bad++; $display("FAIL en_unready got_busy=%b exp=0", seen_busy); end
      b4.wr_en = 1'b1; b4.wr_addr = 8'hff; b4.wr_data = inv_tab[255];
      step();
      b4.wr_en = 1'b0;
      total++; if (b4.table_ready !== 1'b1) begin bad++; $display("FAIL ready_256 got=%b exp=1", b4.table_ready); end
   endtask

   task automatic test_roundtrip();
      run(RT_IN);
      total++; if (res_q[2] !== RT_OUT) begin bad++; $display("FAIL rt_out got=%h exp=%h", res_q[2], RT_OUT); end
      total++; if (lat_q[2] !== 6) begin bad++; $display("FAIL rt_latency got=%0d exp=6", lat_q[2]); end
      total++; if (pulses4 !== 1) begin bad++; $display("FAIL rt_pulses got=%0d exp=1", pulses4); end
      total++; if (b4.state_out !== RT_OUT) begin bad++; $display("FAIL rt_hold got=%h exp=%h", b4.state_out, RT_OUT); end
   endtask

   task automatic test_lanes();
      logic [127:0] st = {$urandom, $urandom, $urandom, $urandom};
      run(RT_IN);
      total++; if (lat_q[0] !== 18) begin bad++; $display("FAIL l1_latency got=%0d exp=18", lat_q[0]); end
      total++; if (res_q[0] !== RT_OUT) begin bad++; $display("FAIL l1_out got=%h exp=%h", res_q[0], RT_OUT); end
      total++; if (lat_q[1] !== 10) begin bad++; $display("FAIL l2_latency got=%0d exp=10", lat_q[1]); end
      total++; if (res_q[1] !== RT_OUT) begin bad++; $display("FAIL l2_out got=%h exp=%h", res_q[1], RT_OUT); end
      run(st);
      total++; if (res_q[0] !== model(st)) begin bad++; $display("FAIL l1_rand got=%h exp=%h", res_q[0], model(st)); end
      total++; if (res_q[1] !== model(st)) begin bad++; $display("FAIL l2_rand got=%h exp=%h", res_q[1], model(st)); end
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         logic [127:0] st = {$urandom, $urandom, $urandom, $urandom};
         run(st);
         total++; if (res_q[2] !== model(st)) begin bad++; $display("FAIL rand_out[%0d] got=%h exp=%h", t, res_q[2], model(st)); end
         total++; if (lat_q[2] !== 6) begin bad++; $display("FAIL rand_latency[%0d] got=%0d exp=6", t, lat_q[2]); end
      end
   endtask

   task automatic test_back_to_back();
      int d1 = -1;
      int d2 = -1;
      logic [127:0] o1 = '0;
      logic [127:0] o2 = '0;
      logic held = 1'b1;
      b4.state_in = '0;
      b4.en = 1'b1;
      step();
      b4.state_in = {16{8'h63}};
      for (int n = 1; n <= 20; n++) begin
         step();
         if (n == 6) b4.en = 1'b0;
         if (b4.done && d1 < 0) begin d1 = n; o1 = b4.state_out; end
         else if (b4.done && d2 < 0) begin d2 = n; o2 = b4.state_out; end
         if (n > 6 && n < 12 && b4.state_out !== {16{8'h52}}) held = 1'b0;
      end
      b4.en = 1'b0;
      total++; if (d1 !== 6) begin bad++; $display("FAIL b2b_first_lat got=%0d exp=6", d1); end
      total++; if (o1 !== {16{8'h52}}) begin bad++; $display("FAIL b2b_first_out got=%h exp=%h", o1, {16{8'h52}}); end
      total++; if (d2 !== 12) begin bad++; $display("FAIL b2b_second_lat got=%0d exp=12", d2); end
      total++; if (o2 !== 128'h0) begin bad++; $display("FAIL b2b_second_out got=%h exp=0", o2); end
      total++; if (held !== 1'b1) begin bad++; $display("FAIL b2b_hold got=%b exp=1", held); end
   endtask

   task automatic test_guards();
      logic [127:0] st = {$urandom, $urandom, $urandom, $urandom};
      logic [127:0] other = ~st;
      int d = -1;
      logic [127:0] o = '0;
      b4.state_in = st;
      b4.en = 1'b1;
      step();
      b4.en = 1'b0;
      step();
      b4.en = 1'b1; b4.state_in = other;
      b4.wr_en = 1'b1; b4.wr_addr = 8'h00; b4.wr_data = 8'hff;
      step();
      b4.en = 1'b0; b4.wr_en = 1'b0;
      for (int n = 3; n <= 30; n++) begin
         step();
         if (b4.done && d < 0) begin d = n; o = b4.state_out; end
      end
      total++; if (d !== 6) begin bad++; $display("FAIL guard_latency got=%0d exp=6", d); end
      total++; if (o !== model(st)) begin bad++; $display("FAIL guard_out got=%h exp=%h", o, model(st)); end
      run('0);
      total++; if (res_q[2] !== {16{8'h52}}) begin bad++; $display("FAIL guard_ram got=%h exp=%h", res_q[2], {16{8'h52}}); end
      total++; if (b4.table_ready !== 1'b1) begin bad++; $display("FAIL guard_ready got=%b exp=1", b4.table_ready); end
   endtask

   task automatic test_reset_midop();
      logic saw_done = 1'b0;
      logic saw_busy = 1'b0;
      b4.state_in = RT_IN;
      b4.en = 1'b1;
      step();
      b4.en = 1'b0;
      step(); step(); step();
      #2 rst = 1'b0;
      #1;
      total++; if (b4.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", b4.busy); end
      total++; if (b4.state_out !== '0) begin bad++; $display("FAIL midrst_out got=%h exp=0", b4.state_out); end
      total++; if (b4.table_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", b4.table_ready); end
      step();
      rst = 1'b1;
      b4.en = 1'b1;
      for (int n = 0; n < 12; n++) begin
         step();
         if (b4.done) saw_done = 1'b1;
         if (b4.busy) saw_busy = 1'b1;
      end
      b4.en = 1'b0;
      total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", saw_done); end
      total++; if (saw_busy !== 1'b0) begin bad++; $display("FAIL midrst_en got_busy=%b exp=0", saw_busy); end
      load_table();
      run(RT_IN);
      total++; if (res_q[2] !== RT_OUT) begin bad++; $display("FAIL reload_out got=%h exp=%h", res_q[2], RT_OUT); end
   endtask

   initial begin
      build_model();
      test_reset();
      test_load();
      test_roundtrip();
      test_lanes();
      test_random();
      test_back_to_back();
      test_guards();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
